// File: rtl/fifo_sample_reader_pkg.sv
// Shared definitions for the audio FIFO read-side controller.
//   - state encoding of the fetch FSM
//   - default byte/sample widths and starvation budget
//   - helper to size the starvation counter
package fifo_sample_reader_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int SAMPLE_W_DEF   = 16;
  localparam int STARVE_MAX_DEF = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Width able to hold 0..max inclusive.
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/fifo_sample_reader_if.sv
// FIFO read port plus sample output path of the sample reader.
//   master : the reader (drives fifo_rd, sample_out, sample_valid)
//   slave  : the FIFO / DAC side (drives fifo_data, fifo_empty)
interface fifo_sample_reader_if #(
  parameter int DATA_W   = 8,
  parameter int SAMPLE_W = 16
);
  logic [DATA_W-1:0]   fifo_data;
  logic                fifo_empty;
  logic                fifo_rd;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;

  modport master (
    input  fifo_data, fifo_empty,
    output fifo_rd, sample_out, sample_valid
  );

  modport slave (
    output fifo_data, fifo_empty,
    input  fifo_rd, sample_out, sample_valid
  );
endinterface

// File: rtl/fifo_sample_reader.sv
// Read-side controller for the 8-bit audio FIFO. On each accepted sample
// tick it pops two bytes (low first), assembles a 16-bit sample and pulses
// sample_valid for one cycle. If the FIFO stays empty for STARVE_MAX fetch
// cycles the sample is abandoned: output muted to 0 and underrun raised.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   sample_tick  sample-rate strobe
//   enable       permits new fetches (an in-flight fetch always finishes)
//   flags_clr    clears the sticky flags (a coincident set wins)
//   bus          FIFO read port + sample output (master modport)
//   busy         FSM not idle
//   underrun     sticky: a sample was abandoned on starvation
//   tick_miss    sticky: a tick arrived while busy (tick dropped)
module fifo_sample_reader
  import fifo_sample_reader_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,   // must be 2*DATA_W
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 enable,
  input  logic                 flags_clr,
  fifo_sample_reader_if.master bus,
  output logic                 busy,
  output logic                 underrun,
  output logic                 tick_miss
);

  localparam int CNT_W = cnt_w(STARVE_MAX);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_nxt;
  logic [DATA_W-1:0]  lo_reg;
  logic               fetch, pop, abandon;

  assign fetch = (state == FETCH_LO) || (state == FETCH_HI);
  // Pop only while fetching and data is present: never underflows the FIFO.
  assign pop   = fetch && !bus.fifo_empty;
  // This empty cycle is the STARVE_MAX-th one for the current sample, so
  // give up now rather than counting further. No pop happens here.
  assign abandon = fetch && bus.fifo_empty &&
                   (starve_cnt == CNT_W'(STARVE_MAX - 1));

  assign bus.fifo_rd = pop;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (sample_tick && enable) begin
          state_nxt      = FETCH_LO;
          starve_cnt_nxt = '0;
        end
      end
      FETCH_LO: begin
        if (pop)          state_nxt = FETCH_HI;
        else if (abandon) state_nxt = IDLE;
        else              starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
      FETCH_HI: begin
        // Counter carries over from FETCH_LO: the budget is per sample.
        if (pop)          state_nxt = DONE;
        else if (abandon) state_nxt = IDLE;
        else              starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      lo_reg           <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      underrun         <= 1'b0;
      tick_miss        <= 1'b0;
    end else begin
      state            <= state_nxt;
      starve_cnt       <= starve_cnt_nxt;
      bus.sample_valid <= 1'b0;

      if (state == FETCH_LO && pop) lo_reg <= bus.fifo_data;

      // Output registered on entry to DONE so the valid pulse coincides
      // with the DONE cycle.
      if (state == FETCH_HI && pop) begin
        bus.sample_out   <= {bus.fifo_data, lo_reg};
        bus.sample_valid <= 1'b1;
      end

      // Abandoned sample: mute; any low byte already popped is dropped.
      if (abandon) begin
        bus.sample_out   <= '0;
        bus.sample_valid <= 1'b1;
      end

      // Set has priority over clear.
      if (abandon)        underrun <= 1'b1;
      else if (flags_clr) underrun <= 1'b0;

      if (sample_tick && busy) tick_miss <= 1'b1;
      else if (flags_clr)      tick_miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_sample_reader.sv
module tb_fifo_sample_reader;

  localparam int STARVE = 64;
  localparam int NEVER  = 1 << 30;

  logic clk, rst_n, sample_tick, enable, flags_clr;
  logic busy, underrun, tick_miss;

  fifo_sample_reader_if #(.DATA_W(8), .SAMPLE_W(16)) ifc ();

  fifo_sample_reader #(.DATA_W(8), .SAMPLE_W(16), .STARVE_MAX(STARVE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .enable     (enable),
    .flags_clr  (flags_clr),
    .bus        (ifc),
    .busy       (busy),
    .underrun   (underrun),
    .tick_miss  (tick_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte schedule: data plus the first cycle it is visible at the FIFO head.
  typedef struct { logic [7:0] d; int avail; } byte_t;
  typedef struct { logic [15:0] s; int at; } exp_t;

  byte_t drv_q[$];   // what the FIFO model presents to the DUT
  byte_t mdl_q[$];   // reference model's view of the same bytes
  exp_t  exp_q[$];   // scoreboard of expected samples

  int cyc = 0;          // number of rising edges so far
  int pop_cnt = 0;
  int last_avail = 0;
  int busy_until = -1;  // last cycle the model considers the reader busy
  bit um = 0, tm = 0;   // model sticky flags
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // FIFO model: pops on fifo_rd at the edge, updates head shortly after.
  always @(posedge clk) begin
    if (rst_n && ifc.fifo_rd) begin
      if (drv_q.size() > 0) void'(drv_q.pop_front());
      pop_cnt++;
    end
    cyc++;
    #1;
    if (drv_q.size() > 0 && drv_q[0].avail <= cyc) begin
      ifc.fifo_empty = 1'b0;
      ifc.fifo_data  = drv_q[0].d;
    end else begin
      ifc.fifo_empty = 1'b1;
      ifc.fifo_data  = 8'($urandom);
    end
  end

  // Monitor: no pop while empty; every valid pulse matches the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ifc.fifo_rd) chk("rd_while_empty", 32'(ifc.fifo_empty), 32'd0);
      if (ifc.sample_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sample", 32'(ifc.sample_out), 32'(e.s));
          chk("valid_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic sched(input logic [7:0] d, input int dly);
    byte_t b;
    b.d = d;
    b.avail = cyc + 1 + dly;
    if (b.avail < last_avail) b.avail = last_avail;
    last_avail = b.avail;
    drv_q.push_back(b);
    mdl_q.push_back(b);
  endtask

  // Drive a one-cycle tick and predict its outcome from the byte schedule.
  task automatic tick(input bit en, input bit clr);
    int t, l, h;
    byte_t lo, hi;
    exp_t e;
    @(negedge clk);
    sample_tick = 1'b1;
    enable      = en;
    flags_clr   = clr;
    t = cyc + 1;   // fetch starts in cycle t
    if (clr) begin um = 0; tm = 0; end
    if (cyc <= busy_until) tm = 1;
    else if (en) begin
      l = (mdl_q.size() == 0) ? NEVER : (mdl_q[0].avail > t ? mdl_q[0].avail : t);
      if (l - t >= STARVE) begin
        e.s = 16'h0; e.at = t + STARVE; busy_until = t + STARVE - 1; um = 1;
      end else begin
        lo = mdl_q.pop_front();
        h = (mdl_q.size() == 0) ? NEVER : (mdl_q[0].avail > l + 1 ? mdl_q[0].avail : l + 1);
        if (h - t - 1 >= STARVE) begin
          // one pop cycle sits inside the window
          e.s = 16'h0; e.at = t + STARVE + 1; busy_until = t + STARVE; um = 1;
        end else begin
          hi = mdl_q.pop_front();
          e.s = {hi.d, lo.d}; e.at = h + 1; busy_until = h + 1;
        end
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    sample_tick = 1'b0;
    flags_clr   = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_until + 1) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, "_underrun"}, 32'(underrun), 32'(um));
    chk({nm, "_tick_miss"}, 32'(tick_miss), 32'(tm));
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        32'({ifc.fifo_rd, ifc.sample_out, ifc.sample_valid, busy, underrun, tick_miss}), 32'd0);
    exp_q.delete(); drv_q.delete(); mdl_q.delete();
    busy_until = -1; last_avail = 0; um = 0; tm = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int p0, mode;
    rst_n = 1'b1; sample_tick = 1'b0; enable = 1'b0; flags_clr = 1'b0;
    #3;
    do_reset();

    // Preloaded 0x34,0x12 -> 0x1234, two pops.
    sched(8'h34, 0); sched(8'h12, 0);
    @(negedge clk);
    p0 = pop_cnt;
    tick(1, 0);
    wait_idle();
    chk("pops_two", 32'(pop_cnt - p0), 32'd2);
    chk_flags("basic");

    // Empty FIFO -> abandon after 64 cycles, mute, underrun.
    p0 = pop_cnt;
    tick(1, 0);
    wait_idle();
    chk("pops_starve", 32'(pop_cnt - p0), 32'd0);
    chk_flags("starve");

    // Low byte present, high byte 10 cycles later -> 0xCDAB.
    sched(8'hAB, 0); sched(8'hCD, 10);
    @(negedge clk);
    tick(1, 1);
    wait_idle();
    chk_flags("late_hi");

    // Back-to-back tick -> miss; then clear coincident with a new miss.
    sched(8'h11, 0); sched(8'h22, 0);
    @(negedge clk);
    tick(1, 0); tick(1, 0);
    wait_idle();
    chk_flags("miss");
    sched(8'h33, 0); sched(8'h44, 0);
    @(negedge clk);
    tick(1, 0); tick(1, 1);
    wait_idle();
    chk_flags("clr_vs_miss");

    // Reset during FETCH_HI, then a clean sample.
    sched(8'h55, 0); sched(8'h66, 30);
    @(negedge clk);
    tick(1, 0);
    @(negedge clk);
    chk("in_fetch_busy", 32'(busy), 32'd1);
    do_reset();
    sched(8'h78, 0); sched(8'h56, 0);
    @(negedge clk);
    tick(1, 0);
    wait_idle();
    chk_flags("after_reset");

    // enable low: four ticks ignored.
    sched(8'h9A, 0); sched(8'hBC, 0);
    @(negedge clk);
    p0 = pop_cnt;
    repeat (4) begin tick(0, 0); repeat (3) @(negedge clk); end
    chk("pops_disabled", 32'(pop_cnt - p0), 32'd0);
    chk_flags("disabled");

    // enable dropped during FETCH_LO: sample completes, next tick ignored.
    tick(1, 0);
    enable = 1'b0;
    wait_idle();
    sched(8'hDE, 0); sched(8'hF0, 0);
    p0 = pop_cnt;
    tick(0, 0);
    repeat (4) @(negedge clk);
    chk("pops_after_drop", 32'(pop_cnt - p0), 32'd0);
    chk_flags("enable_drop");

    // Randomized trials against the schedule-based model.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 9);
      if (mdl_q.size() < 12) begin
        if (mode <= 5) begin
          sched(8'($urandom), 0); sched(8'($urandom), 0);
        end else if (mode <= 7) begin
          sched(8'($urandom), $urandom_range(0, 15));
          sched(8'($urandom), $urandom_range(0, 15));
        end else if (mode == 9) begin
          sched(8'($urandom), 0); sched(8'($urandom), 70);
        end
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      tick($urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0);
      wait_idle();
      chk_flags("rand");
    end

    wait_idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sample_reader.md
Name: fifo_sample_reader

Overview:
- Read-side controller for the 8-bit audio FIFO (depth 16, pointer width 5).
- On each audio sample-rate tick it drains two bytes from the FIFO, low byte first, and assembles one 16-bit sample.
- It presents the sample to the DAC/effects path with a one-cycle valid pulse.
- It owns the FIFO `rd` strobe, handles FIFO starvation with mute-and-flag, and reports missed ticks.

Parameters:
- DATA_W, 8: FIFO byte width.
- SAMPLE_W, 16: output sample width; must equal 2*DATA_W.
- STARVE_MAX, 64: maximum clock cycles spent waiting on an empty FIFO per sample before abandoning it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_tick  in  1  one-cycle sample-rate strobe.
- enable  in  1  permits new sample fetches.
- fifo_data  in  DATA_W  FIFO data_out; combinational read of the head entry, valid while fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  DATA_W-independent 1  FIFO rd strobe; a pop happens at the clock edge where it is high.
- sample_out  out  SAMPLE_W  last assembled sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high whenever state is not IDLE.
- underrun  out  1  sticky: a sample was abandoned due to starvation.
- tick_miss  out  1  sticky: sample_tick arrived while busy.
- flags_clr  in  1  clears underrun and tick_miss.

Behaviour:
- Reset (async assert, sync release): state=IDLE, starve_cnt=0; all outputs 0.
- States: IDLE, FETCH_LO, FETCH_HI, DONE.
- IDLE:
  - If sample_tick & enable, go to FETCH_LO and clear starve_cnt.
  - Ticks with enable=0 are ignored and are not counted as misses.
- FETCH_LO:
  - fifo_rd = !fifo_empty. This output is combinational from state and fifo_empty; it is never asserted outside the FETCH states.
  - If not empty: capture fifo_data into lo_reg and go to FETCH_HI.
  - If empty: starve_cnt += 1.
- FETCH_HI:
  - Same rule; capture fifo_data into the high byte and go to DONE.
- DONE (one cycle):
  - sample_out = {hi, lo}; sample_valid=1 for exactly this cycle.
  - Go to IDLE.
- Starvation:
  - starve_cnt is shared across both FETCH states for one sample.
  - When starve_cnt reaches STARVE_MAX while in a FETCH state with fifo_empty=1:
    - sample_out=0 (mute), sample_valid pulses, underrun sets.
    - State goes directly to IDLE next cycle.
    - A low byte already popped is discarded; no pop occurs in the abandon cycle.
- Latency with a non-empty FIFO:
  - Tick sampled at edge E0.
  - Pops at E1 and E2.
  - sample_valid high in the cycle after E2, i.e. 3 cycles after tick is seen.
  - Minimum tick spacing is 4 clocks.
- tick_miss: sample_tick=1 while busy=1 sets tick_miss. The tick is dropped, not queued.
- Sticky flags:
  - flags_clr clears both flags.
  - A set event in the same cycle as flags_clr wins; the flag stays 1.
- enable deasserted mid-fetch: the current sample completes normally (or starves); no new fetch starts afterwards.
- Reset mid-fetch: immediately returns to reset values; fifo_rd drops asynchronously with the state.
- Byte order is little-endian (low byte written first by the producer). The producer writes whole samples; resynchronisation after an underrun is the producer's responsibility.
- fifo_rd is never asserted when fifo_empty=1, so this block never causes FIFO underflow.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, FETCH_LO=2'd1, FETCH_HI=2'd2, DONE=2'd3);
  - DATA_W/SAMPLE_W defaults;
  - STARVE_MAX default.
- No sub-module is warranted. The FSM, starve counter and sticky flags are implemented in one module of roughly 150 lines.

Test Plan:
- FIFO preloaded with 0x34,0x12, then one tick -> fifo_rd high exactly 2 cycles; sample_out=0x1234; one sample_valid pulse 3 cycles after tick; underrun=0.
- FIFO empty, tick, no writes; STARVE_MAX=64 -> fifo_rd never high; after 64 cycles sample_out=0x0000, sample_valid pulses, underrun=1, state back to IDLE.
- Only 0xAB present at tick, 0xCD written 10 cycles later -> sample_out=0xCDAB; no underrun.
- Second tick issued 1 cycle after the first -> tick_miss=1; only one sample produced. Then flags_clr coincident with a new miss -> tick_miss remains 1.
- rst_n pulsed low during FETCH_HI -> all outputs 0 at once. A tick after release with 2 bytes present produces a correct sample.
- enable=0 with 4 ticks -> no pops, no flags. enable dropped during FETCH_LO -> that sample completes and the next tick is ignored.
